// File: rtl/tape_ram_arbiter.sv
// Arbitrates the main-RAM write port between the CPU and a buffered tape loader, bracketing loads with bank writes.
// Latency: CPU request -> RAM 1 cycle; tape push -> RAM 2 cycles minimum. The CPU stalls only on bank-write cycles; tape pushes are dropped when the FIFO is full.
module tape_ram_arbiter #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] BANK_ADDR  = 16'hFFFF,
    parameter logic [7:0]  BANK_WRITE = 8'h00,
    parameter logic [7:0]  BANK_READ  = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tape_active,
    input  logic        tape_wr,
    input  logic [15:0] tape_addr,
    input  logic [7:0]  tape_dout,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic        cpu_wait,
    output logic        ram_wr,
    output logic        ram_rd,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        busy,
    output logic        tape_overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } tape_ent_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BANK_IN,
        S_LOAD,
        S_DRAIN,
        S_BANK_OUT
    } state_t;

    state_t          state;
    tape_ent_t       mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            cpu_req;
    logic            bank_slot;
    logic            pop;
    logic            push_win;
    logic            push;
    logic            drop;
    tape_ent_t       head;

    always_comb begin
        cpu_req   = cpu_wr | cpu_rd;
        bank_slot = (state == S_BANK_IN) || (state == S_BANK_OUT);
        // The FIFO only gets the port on cycles the CPU leaves free.
        pop       = !cpu_req && (count != '0) && ((state == S_LOAD) || (state == S_DRAIN));
        push_win  = tape_wr && ((state == S_BANK_IN) || (state == S_LOAD));
        push      = push_win && ((count != FULL) || pop);
        drop      = push_win && !push;
        head      = mem[rd_ptr];
        cpu_wait  = bank_slot && cpu_req;
        busy      = (state != S_IDLE);
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {tape_addr, tape_dout};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            ram_wr        <= 1'b0;
            ram_rd        <= 1'b0;
            ram_addr      <= '0;
            ram_din       <= '0;
            tape_overflow <= 1'b0;
        end else begin
            ram_wr <= 1'b0;
            ram_rd <= 1'b0;
            if (bank_slot) begin
                ram_wr   <= 1'b1;
                ram_addr <= BANK_ADDR;
                ram_din  <= (state == S_BANK_IN) ? BANK_WRITE : BANK_READ;
            end else if (cpu_wr) begin
                ram_wr   <= 1'b1;
                ram_addr <= cpu_addr;
                ram_din  <= cpu_dout;
            end else if (cpu_rd) begin
                ram_rd   <= 1'b1;
                ram_addr <= cpu_addr;
            end else if (pop) begin
                ram_wr   <= 1'b1;
                ram_addr <= head.addr;
                ram_din  <= head.data;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (state == S_BANK_IN) begin
                tape_overflow <= 1'b0;
            end
            if (drop) begin
                tape_overflow <= 1'b1;
            end

            case (state)
                S_IDLE:     if (tape_active) state <= S_BANK_IN;
                S_BANK_IN:  state <= S_LOAD;
                S_LOAD:     if (!tape_active) state <= S_DRAIN;
                S_DRAIN:    if (count == '0) state <= S_BANK_OUT;
                S_BANK_OUT: state <= S_IDLE;
                default:    state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tape_ram_arbiter.sv
// Bench for tape_ram_arbiter: a scoreboard of expected RAM accesses, checked as they appear.
module tb_tape_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        tape_active;
    logic        tape_wr;
    logic [15:0] tape_addr;
    logic [7:0]  tape_dout;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_wait;
    logic        ram_wr;
    logic        ram_rd;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        busy;
    logic        tape_overflow;

    tape_ram_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .tape_active   (tape_active),
        .tape_wr       (tape_wr),
        .tape_addr     (tape_addr),
        .tape_dout     (tape_dout),
        .cpu_wr        (cpu_wr),
        .cpu_rd        (cpu_rd),
        .cpu_addr      (cpu_addr),
        .cpu_dout      (cpu_dout),
        .cpu_wait      (cpu_wait),
        .ram_wr        (ram_wr),
        .ram_rd        (ram_rd),
        .ram_addr      (ram_addr),
        .ram_din       (ram_din),
        .busy          (busy),
        .tape_overflow (tape_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend[$];
    int   total = 0;
    int   bad = 0;
    logic mon_en = 1'b0;

    // Every RAM access must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en && (ram_wr || ram_rd)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_access wr=%b rd=%b addr=%h din=%h required none", ram_wr, ram_rd, ram_addr, ram_din);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.rd) begin
                    if (ram_rd !== 1'b1 || ram_wr !== 1'b0 || ram_addr !== e.addr) begin
                        bad++;
                        $display("FAIL ram_read got rd=%b wr=%b addr=%h required rd=1 wr=0 addr=%h", ram_rd, ram_wr, ram_addr, e.addr);
                    end
                end else if (ram_wr !== 1'b1 || ram_rd !== 1'b0 || ram_addr !== e.addr || ram_din !== e.data) begin
                    bad++;
                    $display("FAIL ram_write got wr=%b rd=%b %h<-%h required %h<-%h", ram_wr, ram_rd, ram_addr, ram_din, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.rd = 1'b0; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_rd(input logic [15:0] a);
        exp_t e;
        e.rd = 1'b1; e.addr = a; e.data = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic add_pend(input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.rd = 1'b0; e.addr = a; e.data = d;
        pend.push_back(e);
    endtask

    task automatic flush_pend();
        while (pend.size() != 0) exp_q.push_back(pend.pop_front());
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle_timeout busy=%b required 0", tag, busy);
        end
    endtask

    // Raises tape_active and returns with the DUT in LOAD.
    task automatic start_session();
        tape_active = 1'b1;
        expect_wr(16'hFFFF, 8'h00);
        tick();
        tick();
    endtask

    task automatic end_session(input string tag);
        tape_active = 1'b0;
        expect_wr(16'hFFFF, 8'h20);
        wait_idle(tag);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({ram_wr, ram_rd, ram_addr, ram_din, busy, cpu_wait, tape_overflow} !== 29'd0) begin
            bad++;
            $display("FAIL reset_outputs wr=%b rd=%b addr=%h din=%h busy=%b wait=%b ovf=%b required all 0",
                     ram_wr, ram_rd, ram_addr, ram_din, busy, cpu_wait, tape_overflow);
        end
        reset = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || ram_wr !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle busy=%b wr=%b required 0 0", busy, ram_wr);
        end
    endtask

    task automatic test_basic_session();
        logic [15:0] a [3];
        logic [7:0]  d [3];
        a[0] = 16'h694D; a[1] = 16'h694E; a[2] = 16'h694F;
        d[0] = 8'h11;    d[1] = 8'h22;    d[2] = 8'h33;
        start_session();
        for (int i = 0; i < 3; i++) begin
            tape_wr = 1'b1; tape_addr = a[i]; tape_dout = d[i];
            expect_wr(a[i], d[i]);
            tick();
        end
        tape_wr = 1'b0;
        end_session("basic");
        total++;
        if (busy !== 1'b0 || tape_overflow !== 1'b0) begin
            bad++;
            $display("FAIL basic_end busy=%b ovf=%b required 0 0", busy, tape_overflow);
        end
    endtask

    task automatic test_cpu_priority();
        start_session();
        for (int i = 0; i < 6; i++) begin
            cpu_wr = 1'b1; cpu_addr = 16'h4000; cpu_dout = 8'hAA;
            expect_wr(16'h4000, 8'hAA);
            if (i < 2) begin
                tape_wr = 1'b1; tape_addr = 16'h1000 + 16'(i); tape_dout = 8'h50 + 8'(i);
                add_pend(16'h1000 + 16'(i), 8'h50 + 8'(i));
            end else begin
                tape_wr = 1'b0;
            end
            #1;
            total++;
            if (cpu_wait !== 1'b0) begin
                bad++;
                $display("FAIL cpu_wait_in_load got %b required 0", cpu_wait);
            end
            tick();
            total++;
            if (ram_wr !== 1'b1 || ram_addr !== 16'h4000) begin
                bad++;
                $display("FAIL cpu_latency got wr=%b addr=%h required 1 4000", ram_wr, ram_addr);
            end
        end
        cpu_wr = 1'b0;
        tape_wr = 1'b0;
        flush_pend();
        end_session("cpu_prio");
    endtask

    task automatic test_overflow();
        start_session();
        for (int i = 0; i < 6; i++) begin
            cpu_wr = 1'b1; cpu_addr = 16'h4100; cpu_dout = 8'(i);
            expect_wr(16'h4100, 8'(i));
            tape_wr = 1'b1; tape_addr = 16'h2000 + 16'(i); tape_dout = 8'h60 + 8'(i);
            if (i < 4) add_pend(16'h2000 + 16'(i), 8'h60 + 8'(i));
            tick();
        end
        tape_wr = 1'b0;
        cpu_wr = 1'b0;
        total++;
        if (tape_overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_set got %b required 1", tape_overflow);
        end
        flush_pend();
        end_session("overflow");
        total++;
        if (tape_overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_sticky got %b required 1", tape_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        start_session();
        total++;
        if (tape_overflow !== 1'b0) begin
            bad++;
            $display("FAIL overflow_clear_bank_in got %b required 0", tape_overflow);
        end
        for (int i = 0; i < 4; i++) begin
            cpu_wr = 1'b1; cpu_addr = 16'h4200; cpu_dout = 8'h80 + 8'(i);
            expect_wr(16'h4200, 8'h80 + 8'(i));
            tape_wr = 1'b1; tape_addr = 16'h3000 + 16'(i); tape_dout = 8'h70 + 8'(i);
            add_pend(16'h3000 + 16'(i), 8'h70 + 8'(i));
            tick();
        end
        cpu_wr = 1'b0;
        tape_wr = 1'b1; tape_addr = 16'h3004; tape_dout = 8'h74;
        add_pend(16'h3004, 8'h74);
        flush_pend();
        tick();
        tape_wr = 1'b0;
        total++;
        if (tape_overflow !== 1'b0) begin
            bad++;
            $display("FAIL full_push_pop_ovf got %b required 0", tape_overflow);
        end
        end_session("full_pop");
    endtask

    task automatic test_cpu_bank_in();
        tape_active = 1'b1;
        expect_wr(16'hFFFF, 8'h00);
        tick();
        cpu_wr = 1'b1; cpu_addr = 16'h1234; cpu_dout = 8'h55;
        #1;
        total++;
        if (cpu_wait !== 1'b1) begin
            bad++;
            $display("FAIL cpu_wait_bank_in got %b required 1", cpu_wait);
        end
        tick();
        total++;
        if (ram_addr !== 16'hFFFF || cpu_wait !== 1'b0) begin
            bad++;
            $display("FAIL bank_in_grant got addr=%h wait=%b required ffff 0", ram_addr, cpu_wait);
        end
        expect_wr(16'h1234, 8'h55);
        tick();
        cpu_wr = 1'b0;
        cpu_rd = 1'b1; cpu_addr = 16'h5678;
        expect_rd(16'h5678);
        tick();
        cpu_rd = 1'b0;
        end_session("bank_in");
    endtask

    task automatic test_reset_mid_load();
        start_session();
        for (int i = 0; i < 2; i++) begin
            cpu_wr = 1'b1; cpu_addr = 16'h4300; cpu_dout = 8'h90 + 8'(i);
            expect_wr(16'h4300, 8'h90 + 8'(i));
            tape_wr = 1'b1; tape_addr = 16'h5000 + 16'(i); tape_dout = 8'hA0 + 8'(i);
            tick();
        end
        tape_wr = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        cpu_wr = 1'b0;
        tape_active = 1'b0;
        #1;
        total++;
        if (ram_wr !== 1'b0 || ram_addr !== 16'h0 || ram_din !== 8'h0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got wr=%b addr=%h din=%h busy=%b required 0 0000 00 0", ram_wr, ram_addr, ram_din, busy);
        end
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        start_session();
        tape_wr = 1'b1; tape_addr = 16'h3333; tape_dout = 8'h77;
        expect_wr(16'h3333, 8'h77);
        tick();
        tape_wr = 1'b0;
        end_session("after_reset");
    endtask

    task automatic test_min_session();
        int n = 0;
        tape_active = 1'b1;
        expect_wr(16'hFFFF, 8'h00);
        expect_wr(16'hFFFF, 8'h20);
        tick();
        tape_active = 1'b0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n !== 4) begin
            bad++;
            $display("FAIL min_session busy_cycles=%0d required 4", n);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        tape_active = 1'b0; tape_wr = 1'b0; tape_addr = '0; tape_dout = '0;
        cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_addr = '0; cpu_dout = '0;
        test_reset();
        mon_en = 1'b1;
        test_basic_session();
        test_cpu_priority();
        test_overflow();
        test_full_push_pop();
        test_cpu_bank_in();
        test_reset_mid_load();
        test_min_session();
        tick();
        mon_en = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected count=%0d required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tape_ram_arbiter.md
# tape_ram_arbiter

Shares the single main-RAM write port between the CPU and the cassette/TAP loader, which emits one-cycle `tape_wr` strobes with `tape_addr`/`tape_dout` during an ioctl download. Tape writes are buffered in a small FIFO and retired only on cycles the CPU leaves the port free. The block brackets each load session with the bank-switch writes to `BANK_ADDR`: select write bank before the first data byte, restore read bank after the last byte has drained. It sits between the loader, the CPU bus and the RAM in the top level.

## Interface
- `FIFO_DEPTH`, 4: tape write buffer depth; power of 2, ≥2.
- `BANK_ADDR`, 16'hFFFF: bank-switch register address.
- `BANK_WRITE`, 8'h00: value written at session start.
- `BANK_READ`, 8'h20: value written at session end.

Ports:
- `clk` in 1: single system clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `tape_active` in 1: loader session level (ioctl_download).
- `tape_wr` in 1: one-cycle write strobe from loader.
- `tape_addr` in 16: loader write address.
- `tape_dout` in 8: loader write data.
- `cpu_wr` in 1: CPU write request this cycle.
- `cpu_rd` in 1: CPU read request this cycle.
- `cpu_addr` in 16: CPU address.
- `cpu_dout` in 8: CPU write data.
- `cpu_wait` out 1: CPU must hold its request; combinational.
- `ram_wr` out 1: registered RAM write enable.
- `ram_rd` out 1: registered RAM read enable.
- `ram_addr` out 16: registered RAM address.
- `ram_din` out 8: registered RAM write data.
- `busy` out 1: state ≠ IDLE; combinational.
- `tape_overflow` out 1: sticky; a tape write was dropped.

## Operation
- States: IDLE, BANK_IN, LOAD, DRAIN, BANK_OUT.
- IDLE: `tape_active`=1 → BANK_IN. Level-sensitive; `tape_wr` ignored in IDLE.
- BANK_IN, one cycle: issue write `BANK_ADDR`←`BANK_WRITE`. Clear `tape_overflow`. Go to LOAD.
- LOAD: FIFO pushes accepted. `tape_active`=0 → DRAIN.
- DRAIN: pushes ignored, with no overflow flag. FIFO empty and no pop this cycle → BANK_OUT.
- BANK_OUT, one cycle: issue write `BANK_ADDR`←`BANK_READ`. Go to IDLE.
  - If `tape_active` is already high again, IDLE re-enters BANK_IN on the next cycle.
- Push is accepted in BANK_IN and LOAD when `count<FIFO_DEPTH`, or when count is full and a pop occurs in the same cycle. Otherwise the entry is dropped and `tape_overflow`←1.
- Port grant, evaluated each cycle:
  - BANK_IN/BANK_OUT: bank write wins. `cpu_wait`=1 whenever the CPU requests; the CPU request is not forwarded.
  - Other states: `cpu_wr`/`cpu_rd` wins and is forwarded. A FIFO pop happens only on a cycle with no CPU request, when FIFO is non-empty and state ∈ {LOAD, DRAIN}.
- `cpu_wait` is 0 outside BANK_IN/BANK_OUT. The CPU is never stalled by FIFO traffic.
- Granted CPU read: `ram_rd`=1, `ram_addr`=`cpu_addr`, `ram_wr`=0.
- No grant: `ram_wr`=`ram_rd`=0. `ram_addr`/`ram_din` hold their last values.
- Count is a ($clog2(FIFO_DEPTH)+1)-bit field. Read/write pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset values: state IDLE, FIFO empty, pointers 0, `ram_wr`=`ram_rd`=0, `ram_addr`=0, `ram_din`=0, `tape_overflow`=0. From outputs: `busy`=0, `cpu_wait`=0.
- Reset mid-session: FIFO contents are discarded and no BANK_OUT write is issued. The top level reloads.
- CPU latency: request at cycle N → `ram_*` at N+1.
- Tape latency: push at N into an empty FIFO with no CPU request at N+1 → pop at N+1 → `ram_wr` at N+2.
- Bank write: BANK_IN entered at N → `ram_wr` with `BANK_ADDR`/`BANK_WRITE` at N+1.
- A push at N is visible to pop at N+1, not at N. There is no fall-through.
- Tape entries retire in push order; addresses and data are unmodified.
- Minimum session from `tape_active` rise to IDLE, with no data: IDLE→BANK_IN→LOAD→DRAIN→BANK_OUT→IDLE, 4 cycles.

## Test plan
- Idle CPU, `tape_active` raised, 3 pushes ($694D←$11, $694E←$22, $694F←$33), then `tape_active` dropped. Required `ram_wr` sequence: $FFFF←$00, $694D←$11, $694E←$22, $694F←$33, $FFFF←$20. Then `busy`=0.
- CPU writes $4000←$AA every cycle while 2 tape pushes are pending. All CPU writes appear at N+1 with `cpu_wait`=0. Tape writes retire only after the CPU goes idle, in order.
- `FIFO_DEPTH`=4, CPU busy continuously, 6 pushes. The first 4 are kept, the 5th and 6th are dropped, and `tape_overflow`=1. The flag stays set through BANK_OUT and clears at the next BANK_IN.
- Push while full with a simultaneous pop. The push is accepted, count stays 4, and `tape_overflow` stays 0.
- `cpu_wr` held during the BANK_IN cycle. `cpu_wait`=1 for that cycle only, the bank write goes out, and the CPU write is issued one cycle later.
- `reset` asserted in LOAD with 2 entries queued. Outputs are 0 immediately (asynchronous), no further `ram_wr`, and the next session starts at BANK_IN with an empty FIFO.
